// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store unit for a MIPS-style pipeline. It takes the effective byte
// address from the ALU together with the opcode and the store source register.
// It then runs one handshaked access on a 32-bit word-addressed data memory
// port. Supported operations are lb, lh, lw, sb, sh and sw. Byte order is
// big-endian: byte offset 0 is bits [31:24].
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid    request from the execute stage (held until req_ready)
//   req_ready    unit idle and able to accept a request
//   opcode       MIPS opcode (lb/lh/lw/sb/sh/sw, anything else is rejected)
//   ALU_result   effective byte address
//   rt_reg       store data source
//   mem_req      memory request, held until mem_ack
//   mem_we       1 = write, 0 = read
//   mem_addr     word-aligned address
//   mem_be       byte enables, bit 3 = bits [31:24]
//   mem_wdata    store data replicated across lanes
//   mem_rdata    read data, valid with mem_ack
//   mem_ack      memory completion strobe (only looked at in REQ)
//   done         one-cycle completion pulse
//   load_data    sign-extended load result, held until the next load completes
//   err          status valid with done: 00 ok, 01 misaligned, 10 timeout,
//                11 unsupported opcode
//
// TIMEOUT_CYCLES (1..255) is the number of REQ cycles allowed without mem_ack
// before the access is abandoned.
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  opcode,
    input  logic [31:0] ALU_result,
    input  logic [31:0] rt_reg,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  err
);

    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_LH = 6'b100001;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_UNSUP    = 2'b11;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    state_e      state;
    size_e       size_q;
    logic [1:0]  off_q;
    logic [7:0]  tmo_cnt;

    // Decode of the incoming request, used only on the accept cycle.
    logic        dec_valid;
    logic        dec_store;
    size_e       dec_size;
    logic        dec_misaligned;
    logic [7:0]  tmo_cnt_next;

    // -------------------------------------------------------------------------
    // Lane helpers
    // -------------------------------------------------------------------------

    // Byte enables for an access of the given size at the given byte offset.
    function automatic logic [3:0] lane_enables(input size_e size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b1000 >> off;
            SZ_HALF: be = off[1] ? 4'b0011 : 4'b1100;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated so that every candidate lane carries the value.
    // The memory picks the lane(s) with mem_be.
    function automatic logic [31:0] store_lanes(input size_e size, input logic [31:0] rt);
        logic [31:0] wd;
        case (size)
            SZ_BYTE: wd = {4{rt[7:0]}};
            SZ_HALF: wd = {2{rt[15:0]}};
            default: wd = rt;
        endcase
        return wd;
    endfunction

    // Select the addressed byte or halfword (big-endian) and sign-extend it.
    function automatic logic [31:0] extract_load(input size_e size, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = rdata[31:24];
            2'd1:    b = rdata[23:16];
            2'd2:    b = rdata[15:8];
            default: b = rdata[7:0];
        endcase
        h = off[1] ? rdata[15:0] : rdata[31:16];
        case (size)
            SZ_BYTE: res = {{24{b[7]}}, b};
            SZ_HALF: res = {{16{h[15]}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    // NOTE: combinational logic uses blocking '=' and gives every output a
    // default first, so no path can leave a signal unassigned and infer a latch.
    always_comb begin
        dec_valid = 1'b1;
        dec_store = 1'b0;
        dec_size  = SZ_WORD;
        case (opcode)
            OP_LB:   dec_size = SZ_BYTE;
            OP_LH:   dec_size = SZ_HALF;
            OP_LW:   dec_size = SZ_WORD;
            OP_SB: begin
                dec_size  = SZ_BYTE;
                dec_store = 1'b1;
            end
            OP_SH: begin
                dec_size  = SZ_HALF;
                dec_store = 1'b1;
            end
            OP_SW: begin
                dec_size  = SZ_WORD;
                dec_store = 1'b1;
            end
            default: dec_valid = 1'b0;
        endcase

        // Bytes are never misaligned; halves need addr[0]=0, words addr[1:0]=0.
        case (dec_size)
            SZ_HALF: dec_misaligned = ALU_result[0];
            SZ_WORD: dec_misaligned = |ALU_result[1:0];
            default: dec_misaligned = 1'b0;
        endcase
    end

    assign tmo_cnt_next = tmo_cnt + 8'd1;

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            size_q    <= SZ_WORD;
            off_q     <= 2'b00;
            tmo_cnt   <= 8'd0;
            req_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            done      <= 1'b0;
            load_data <= 32'd0;
            err       <= ERR_OK;
        end else begin
            // done is a single-cycle pulse: only the entry into DONE raises it.
            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        err       <= ERR_OK;
                        tmo_cnt   <= 8'd0;
                        if (!dec_valid) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= ERR_UNSUP;
                        end else if (dec_misaligned) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= ERR_MISALIGN;
                        end else begin
                            // All memory-side fields are loaded together here
                            // and stay untouched for the whole REQ state.
                            state     <= ST_REQ;
                            size_q    <= dec_size;
                            off_q     <= ALU_result[1:0];
                            mem_req   <= 1'b1;
                            mem_we    <= dec_store;
                            mem_addr  <= {ALU_result[31:2], 2'b00};
                            mem_be    <= lane_enables(dec_size, ALU_result[1:0]);
                            mem_wdata <= store_lanes(dec_size, rt_reg);
                        end
                    end
                end

                ST_REQ: begin
                    tmo_cnt <= tmo_cnt_next;
                    // The ack check comes first so an ack wins over a timeout
                    // that expires in the same cycle.
                    if (mem_ack) begin
                        state   <= ST_DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        err     <= ERR_OK;
                        if (!mem_we) begin
                            load_data <= extract_load(size_q, off_q, mem_rdata);
                        end
                    end else if (tmo_cnt_next == TMO_LIMIT) begin
                        state   <= ST_DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        err     <= ERR_TIMEOUT;
                    end
                end

                ST_DONE: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Table-driven bench for mem_access_unit built with TIMEOUT_CYCLES = 4. Each
// table record holds one request, the memory's behaviour (ack delay or no ack)
// and the hand-computed outputs. A few hand-written sequences cover reset
// state, mem_ack while idle, and reset in the middle of an access.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_RT  = 6'b000000;
    localparam logic [5:0] OP_LWL = 6'b100010;

    localparam int NVEC = 18;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  opcode;
    logic [31:0] ALU_result;
    logic [31:0] rt_reg;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        done;
    logic [31:0] load_data;
    logic [1:0]  err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] rdata;
        int          ack_wait;   // REQ cycles without ack before the ack cycle
        bit          ack_en;     // 0 = memory never answers
        int          exp_req;    // cycles with mem_req high
        bit          exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;  // only compared for stores
        int          exp_done;   // cycle of the done pulse, counted from accept
        logic [1:0]  exp_err;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs [NVEC];

    mem_access_unit #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .opcode     (opcode),
        .ALU_result (ALU_result),
        .rt_reg     (rt_reg),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .done       (done),
        .load_data  (load_data),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Apply one table record, starting at a negedge with the unit idle, and
    // end on the negedge after the done pulse.
    task automatic run_vec(input vec_t v, input int idx);
        int          req_cnt;
        int          done_cyc;
        int          waited;
        logic        saw_done;
        logic        stable_ok;
        logic        ready_ok;
        logic        got_we;
        logic [31:0] got_addr;
        logic [3:0]  got_be;
        logic [31:0] got_wdata;
        logic [1:0]  got_err;
        logic [31:0] got_load;

        req_cnt   = 0;
        done_cyc  = 0;
        saw_done  = 1'b0;
        stable_ok = 1'b1;
        ready_ok  = 1'b1;
        got_we    = 1'b0;
        got_addr  = 32'd0;
        got_be    = 4'd0;
        got_wdata = 32'd0;
        got_err   = 2'd0;
        got_load  = 32'd0;

        waited = 0;
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("v%0d.ready_at_start", idx), {31'd0, req_ready}, 32'd1);

        opcode     = v.op;
        ALU_result = v.addr;
        rt_reg     = v.rt;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        for (int c = 1; c <= 40 && !saw_done; c++) begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
            if (req_ready) ready_ok = 1'b0;
            if (mem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    got_we    = mem_we;
                    got_addr  = mem_addr;
                    got_be    = mem_be;
                    got_wdata = mem_wdata;
                end else if (mem_we !== got_we || mem_addr !== got_addr ||
                             mem_be !== got_be || mem_wdata !== got_wdata) begin
                    stable_ok = 1'b0;
                end
                if (v.ack_en && req_cnt == v.ack_wait + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
            end
            if (done) begin
                saw_done = 1'b1;
                done_cyc = c;
                got_err  = err;
                got_load = load_data;
            end
        end
        mem_ack = 1'b0;

        check($sformatf("v%0d.done_seen", idx), {31'd0, saw_done}, 32'd1);
        check($sformatf("v%0d.done_cycle", idx), done_cyc, v.exp_done);
        check($sformatf("v%0d.req_cycles", idx), req_cnt, v.exp_req);
        check($sformatf("v%0d.err", idx), {30'd0, got_err}, {30'd0, v.exp_err});
        check($sformatf("v%0d.load_data", idx), got_load, v.exp_load);
        check($sformatf("v%0d.ready_low_busy", idx), {31'd0, ready_ok}, 32'd1);
        if (v.exp_req > 0) begin
            check($sformatf("v%0d.mem_we", idx), {31'd0, got_we}, {31'd0, v.exp_we});
            check($sformatf("v%0d.mem_addr", idx), got_addr, v.exp_addr);
            check($sformatf("v%0d.mem_be", idx), {28'd0, got_be}, {28'd0, v.exp_be});
            check($sformatf("v%0d.req_stable", idx), {31'd0, stable_ok}, 32'd1);
            if (v.exp_we) begin
                check($sformatf("v%0d.mem_wdata", idx), got_wdata, v.exp_wdata);
            end
        end

        // One cycle after the pulse the unit must be idle again.
        @(negedge clk);
        check($sformatf("v%0d.done_pulse_end", idx), {31'd0, done}, 32'd0);
        check($sformatf("v%0d.ready_after", idx), {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic any_done;

        //                op      addr          rt            rdata         wt en req we addr          be       wdata         dn err    load
        vecs[0]  = '{OP_SB,  32'h0000_1001, 32'h0000_00AB, 32'h0000_0000, 0, 1, 1, 1, 32'h0000_1000, 4'b0100, 32'hABAB_ABAB, 2, 2'b00, 32'h0000_0000};
        vecs[1]  = '{OP_LB,  32'h0000_1003, 32'h0000_0000, 32'h1122_33F4, 3, 1, 4, 0, 32'h0000_1000, 4'b0001, 32'h0000_0000, 5, 2'b00, 32'hFFFF_FFF4};
        vecs[2]  = '{OP_LH,  32'h0000_1002, 32'h0000_0000, 32'h1234_8001, 0, 1, 1, 0, 32'h0000_1000, 4'b0011, 32'h0000_0000, 2, 2'b00, 32'hFFFF_8001};
        vecs[3]  = '{OP_LH,  32'h0000_1000, 32'h0000_0000, 32'h7FFE_0000, 0, 1, 1, 0, 32'h0000_1000, 4'b1100, 32'h0000_0000, 2, 2'b00, 32'h0000_7FFE};
        vecs[4]  = '{OP_LW,  32'h0000_1002, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1, 2'b01, 32'h0000_7FFE};
        vecs[5]  = '{OP_RT,  32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1, 2'b11, 32'h0000_7FFE};
        vecs[6]  = '{OP_SW,  32'h0000_2000, 32'hDEAD_BEEF, 32'h0000_0000, 0, 0, 4, 1, 32'h0000_2000, 4'b1111, 32'hDEAD_BEEF, 5, 2'b10, 32'h0000_7FFE};
        vecs[7]  = '{OP_SW,  32'h0000_2000, 32'hDEAD_BEEF, 32'h0000_0000, 3, 1, 4, 1, 32'h0000_2000, 4'b1111, 32'hDEAD_BEEF, 5, 2'b00, 32'h0000_7FFE};
        vecs[8]  = '{OP_SH,  32'h0000_3003, 32'h1234_CAFE, 32'h0000_0000, 0, 0, 0, 0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1, 2'b01, 32'h0000_7FFE};
        vecs[9]  = '{OP_SH,  32'h0000_3002, 32'h1234_CAFE, 32'h0000_0000, 0, 1, 1, 1, 32'h0000_3000, 4'b0011, 32'hCAFE_CAFE, 2, 2'b00, 32'h0000_7FFE};
        vecs[10] = '{OP_LB,  32'h0000_4001, 32'h0000_0000, 32'h0080_FF00, 1, 1, 2, 0, 32'h0000_4000, 4'b0100, 32'h0000_0000, 3, 2'b00, 32'hFFFF_FF80};
        vecs[11] = '{OP_LB,  32'h0000_4002, 32'h0000_0000, 32'h0080_7F00, 0, 1, 1, 0, 32'h0000_4000, 4'b0010, 32'h0000_0000, 2, 2'b00, 32'h0000_007F};
        vecs[12] = '{OP_LW,  32'h0000_4004, 32'h0000_0000, 32'h89AB_CDEF, 0, 1, 1, 0, 32'h0000_4004, 4'b1111, 32'h0000_0000, 2, 2'b00, 32'h89AB_CDEF};
        vecs[13] = '{OP_LB,  32'h0000_4000, 32'h0000_0000, 32'hA500_0000, 2, 1, 3, 0, 32'h0000_4000, 4'b1000, 32'h0000_0000, 4, 2'b00, 32'hFFFF_FFA5};
        vecs[14] = '{OP_LWL, 32'h0000_4000, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1, 2'b11, 32'hFFFF_FFA5};
        vecs[15] = '{OP_LH,  32'h0000_5000, 32'h0000_0000, 32'h0000_0000, 0, 0, 4, 0, 32'h0000_5000, 4'b1100, 32'h0000_0000, 5, 2'b10, 32'hFFFF_FFA5};
        vecs[16] = '{OP_SB,  32'h0000_5003, 32'h1234_5678, 32'h0000_0000, 0, 1, 1, 1, 32'h0000_5000, 4'b0001, 32'h7878_7878, 2, 2'b00, 32'hFFFF_FFA5};
        vecs[17] = '{OP_LW,  32'h0000_6001, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1, 2'b01, 32'hFFFF_FFA5};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        opcode     = 6'd0;
        ALU_result = 32'd0;
        rt_reg     = 32'd0;
        mem_rdata  = 32'd0;
        mem_ack    = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check("rst.mem_req",   {31'd0, mem_req},   32'd0);
        check("rst.mem_we",    {31'd0, mem_we},    32'd0);
        check("rst.mem_addr",  mem_addr,           32'd0);
        check("rst.mem_be",    {28'd0, mem_be},    32'd0);
        check("rst.mem_wdata", mem_wdata,          32'd0);
        check("rst.done",      {31'd0, done},      32'd0);
        check("rst.load_data", load_data,          32'd0);
        check("rst.err",       {30'd0, err},       32'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // mem_ack while idle must not complete anything or touch load_data.
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        any_done  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || mem_req) any_done = 1'b1;
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        check("idle_ack.no_activity", {31'd0, any_done}, 32'd0);
        check("idle_ack.load_data",   load_data,         32'hFFFF_FFA5);

        // Reset in the middle of a load: mem_req drops at once, no done pulse.
        opcode     = OP_LW;
        ALU_result = 32'h0000_6000;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("midrst.req_before", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.req_dropped", {31'd0, mem_req},   32'd0);
        check("midrst.ready_async", {31'd0, req_ready}, 32'd1);
        any_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done || mem_req) any_done = 1'b1;
        end
        check("midrst.no_done",   {31'd0, any_done},  32'd0);
        check("midrst.req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst.load_data", load_data,          32'd0);
        check("midrst.err",       {30'd0, err},       32'd0);

        // A normal access still works after the aborted one.
        run_vec(vecs[12], 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Consumes the effective address produced by the ALU (ALU_result) together with opcode and rt_reg.
- Performs the MIPS load/store data access: lb, lh, lw, sb, sh, sw.
- Multi-cycle, handshaked master toward a 32-bit word-addressed data memory port. Sits between the execute stage and data memory.
- Produces a sign-extended load result, byte enables and replicated store data, and reports alignment, unsupported-opcode and timeout errors.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in REQ without mem_ack before aborting (1..255).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  operation request from execute stage.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- opcode  input  6  MIPS opcode: 100000 lb, 100001 lh, 100011 lw, 101000 sb, 101001 sh, 101011 sw.
- ALU_result  input  32  effective byte address.
- rt_reg  input  32  store data source.
- mem_req  output  1  memory access request, held until acked.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
- mem_be  output  4  byte enables; bit 3 = bits [31:24].
- mem_wdata  output  32  store data, lane-replicated.
- mem_rdata  input  32  read data, valid when mem_ack high.
- mem_ack  input  1  memory completion strobe.
- done  output  1  one-cycle completion pulse.
- load_data  output  32  load result; holds until next load completes.
- err  output  2  status, valid with done: 00 ok, 01 misaligned, 10 timeout, 11 unsupported opcode.

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0; done=0; load_data=0; err=00; timeout counter=0.
- Byte order is big-endian: byte offset 0 maps to bits [31:24], offset 3 to bits [7:0].
- IDLE:
  - Accept on req_valid&req_ready. Capture opcode, address, rt_reg.
  - Unsupported opcode -> DONE with err=11.
  - Misaligned access -> DONE with err=01; no mem_req ever asserted. Misaligned means: lh/sh with addr[0]=1, or lw/sw with addr[1:0]!=00.
  - Otherwise -> REQ.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are stable for the whole state.
  - mem_be:
    - byte: one-hot, 1000>>addr[1:0].
    - half: 1100 if addr[1]=0, else 0011.
    - word: 1111.
  - mem_wdata:
    - sb: {4{rt[7:0]}}.
    - sh: {2{rt[15:0]}}.
    - sw: rt.
  - Timeout counter increments each REQ cycle.
  - mem_ack=1 sampled -> DONE, err=00. For loads, load_data is registered from mem_rdata:
    - lb: selected byte, sign-extended.
    - lh: selected half, sign-extended.
    - lw: full word.
  - Counter reaching TIMEOUT_CYCLES with no ack -> DONE, err=10, load_data unchanged.
  - mem_ack and timeout in the same cycle: ack wins.
- DONE:
  - mem_req=0, done=1 for exactly one cycle, err valid, then -> IDLE.
  - req_ready=0 in DONE and REQ.
- Latency from accept to done:
  - error paths: 1 cycle.
  - memory paths: 2 cycles minimum (ack in the first REQ cycle), plus one cycle per cycle of ack wait.
- Stores never modify load_data.
- mem_ack outside REQ is ignored.
- req_valid outside IDLE is ignored; the requester must hold its request until req_ready.
- Reset mid-operation aborts immediately: mem_req drops asynchronously and no done pulse is generated.
- err is cleared to 00 on the next accept.

Test Plan:
- sb, ALU_result=0x00001001, rt_reg=0x000000AB, ack on first REQ cycle -> mem_addr=0x00001000, mem_we=1, mem_be=0100, mem_wdata=0xABABABAB; done 2 cycles after accept; err=00.
- lb, addr 0x00001003, mem_rdata=0x112233F4 with ack after 3 wait cycles -> load_data=0xFFFFFFF4, done at cycle 5 after accept, err=00.
- lh, addr 0x00001002, mem_rdata=0x12348001 -> mem_be=0011, load_data=0xFFFF8001.
- lh, addr 0x00001000, mem_rdata=0x7FFE0000 -> load_data=0x00007FFE.
- lw, addr 0x00001002 -> no mem_req; done 1 cycle after accept, err=01, load_data unchanged.
- opcode 000000 (R-type) -> done 1 cycle after accept, err=11, no mem_req.
- sw with TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_req high exactly 4 cycles, then done with err=10.
- Repeat with mem_ack in the 4th cycle -> err=00.
- lw in REQ, rst_n pulsed low -> mem_req=0 immediately, no done pulse.
- After rst_n release -> req_ready=1, load_data=0.
